// File: rtl/div16_seq.sv
// Sequential 16-bit restoring divider: one quotient bit per cycle, start/busy/done handshake.
// Optional macro DIV16_SIGNED_EN selects two's-complement operands (sign fix-up at accept/commit).
module div16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [15:0] Dividend,
    input  logic [15:0] Divisor,
    output logic [15:0] Quotient,
    output logic [15:0] Remainder,
    output logic        DivZero,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic [15:0] r_reg, q_reg, d_reg;
    logic [15:0] quot_reg, rem_reg;
    logic        dz_reg;

    logic        accept;
    logic        div_by_zero;
    logic        last;
    logic [16:0] trial;
    logic        fits;
    logic [15:0] r_step, q_step;
    logic [15:0] dvd_mag, dvs_mag;
    logic [15:0] quot_final, rem_final;

    assign accept      = Start && (state_reg != RUN);
    assign div_by_zero = (Divisor == 16'd0);
    assign last        = (cnt_reg == 5'd15);

    // Trial subtract of the divisor from the shifted partial remainder; borrow means "restore".
    assign trial  = {r_reg, q_reg[15]} - {1'b0, d_reg};
    assign fits   = ~trial[16];
    assign r_step = fits ? trial[15:0] : {r_reg[14:0], q_reg[15]};
    assign q_step = {q_reg[14:0], fits};

`ifdef DIV16_SIGNED_EN
    logic neg_q_reg, neg_r_reg;

    assign dvd_mag    = Dividend[15] ? (~Dividend + 16'd1) : Dividend;
    assign dvs_mag    = Divisor[15]  ? (~Divisor  + 16'd1) : Divisor;
    assign quot_final = neg_q_reg ? (~q_step + 16'd1) : q_step;
    assign rem_final  = neg_r_reg ? (~r_step + 16'd1) : r_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (accept && !div_by_zero) begin
            neg_q_reg <= Dividend[15] ^ Divisor[15];
            neg_r_reg <= Dividend[15];
        end
    end
`else
    assign dvd_mag    = Dividend;
    assign dvs_mag    = Divisor;
    assign quot_final = q_step;
    assign rem_final  = r_step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, FIN: begin
                if (Start) begin
                    state_next = div_by_zero ? FIN : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = FIN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= 5'd0;
            r_reg    <= 16'd0;
            q_reg    <= 16'd0;
            d_reg    <= 16'd0;
            quot_reg <= 16'd0;
            rem_reg  <= 16'd0;
            dz_reg   <= 1'b0;
        end else if (accept) begin
            if (div_by_zero) begin
                quot_reg <= 16'hFFFF;
                rem_reg  <= Dividend;
                dz_reg   <= 1'b1;
            end else begin
                r_reg   <= 16'd0;
                q_reg   <= dvd_mag;
                d_reg   <= dvs_mag;
                cnt_reg <= 5'd0;
                dz_reg  <= 1'b0;
            end
        end else if (state_reg == RUN) begin
            r_reg   <= r_step;
            q_reg   <= q_step;
            cnt_reg <= cnt_reg + 5'd1;
            if (last) begin
                quot_reg <= quot_final;
                rem_reg  <= rem_final;
            end
        end
    end

    assign Quotient  = quot_reg;
    assign Remainder = rem_reg;
    assign DivZero   = dz_reg;
    assign Busy      = (state_reg == RUN);
    assign Done      = (state_reg == FIN);

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed plan cases plus random divides against an arithmetic model.
module tb_div16_seq;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [15:0] Dividend;
    logic [15:0] Divisor;
    logic [15:0] Quotient;
    logic [15:0] Remainder;
    logic        DivZero;
    logic        Busy;
    logic        Done;

    int total = 0;
    int bad   = 0;

    div16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division from the operand values.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic z);
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIV16_SIGNED_EN
            int sa, sb, sq, sr;
            sa = int'($signed(a));
            sb = int'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[15:0];
            r  = sr[15:0];
`else
            q = a / b;
            r = a % b;
`endif
            z = 1'b0;
        end
    endtask

    // One divide. now=1 issues Start in the current (Done) cycle; intr_cyc>0 pulses a
    // second Start (9/3) at that cycle of the run, which must be ignored.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b, input string tag,
                           input bit now, input int intr_cyc);
        logic [15:0] eq, er, q_before;
        logic        ez, busy_seen;
        int          cyc;
        model(a, b, eq, er, ez);
        if (!now) @(negedge clk);
        q_before = Quotient;
        Start    = 1'b1;
        Dividend = a;
        Divisor  = b;
        @(negedge clk);
        Start     = 1'b0;
        Dividend  = 16'($urandom);
        Divisor   = 16'($urandom);
        cyc       = 1;
        busy_seen = 1'b0;
        while (!Done && cyc < 40) begin
            busy_seen |= Busy;
            if (cyc == 8) check({tag, "_hold"}, {16'd0, Quotient}, {16'd0, q_before});
            @(negedge clk);
            cyc++;
            if (intr_cyc > 0 && cyc == intr_cyc) begin
                Start = 1'b1; Dividend = 16'd9; Divisor = 16'd3;
            end else begin
                Start = 1'b0;
            end
        end
        Start = 1'b0;
        check({tag, "_lat"}, cyc, ez ? 32'd1 : 32'd17);
        check({tag, "_busy"}, {31'd0, busy_seen}, {31'd0, ~ez});
        check({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
        check({tag, "_q"}, {16'd0, Quotient}, {16'd0, eq});
        check({tag, "_r"}, {16'd0, Remainder}, {16'd0, er});
        check({tag, "_dz"}, {31'd0, DivZero}, {31'd0, ez});
        $display("div %s: %0h / %0h -> q=%0h r=%0h dz=%0b lat=%0d", tag, a, b,
                 Quotient, Remainder, DivZero, cyc);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int          sel;
        bit          done_seen;
        rst_n    = 1'b0;
        Start    = 1'b0;
        Dividend = 16'd0;
        Divisor  = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_q", {16'd0, Quotient}, 32'd0);
        check("rst_r", {16'd0, Remainder}, 32'd0);
        check("rst_flags", {29'd0, DivZero, Busy, Done}, 32'd0);
        rst_n = 1'b1;

        run_div(16'd100, 16'd7, "basic", 1'b0, 0);
        run_div(16'hFFFF, 16'd1, "max_by_1", 1'b0, 0);
        run_div(16'd3, 16'hFFFF, "small_by_max", 1'b0, 0);
        run_div(16'd1234, 16'd0, "divzero", 1'b0, 0);
        run_div(16'd50, 16'd5, "start_busy", 1'b0, 5);
        run_div(16'd77, 16'd4, "back2back", 1'b1, 0);
        run_div(16'd500, 16'd0, "b2b_dz", 1'b1, 0);
        run_div(16'd9, 16'd2, "after_dz", 1'b1, 0);
`ifdef DIV16_SIGNED_EN
        run_div(16'hFFF9, 16'd2, "s_neg7_by2", 1'b0, 0);
        run_div(16'h8000, 16'hFFFF, "s_min_by_m1", 1'b0, 0);
        run_div(16'd7, 16'hFFFE, "s_7_by_m2", 1'b0, 0);
`endif

        // Reset in the middle of a divide.
        @(negedge clk);
        Start = 1'b1; Dividend = 16'd1000; Divisor = 16'd3;
        @(negedge clk);
        Start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_q", {16'd0, Quotient}, 32'd0);
        check("midrst_r", {16'd0, Remainder}, 32'd0);
        check("midrst_flags", {29'd0, DivZero, Busy, Done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            done_seen |= Done;
        end
        check("midrst_no_done", {31'd0, done_seen}, 32'd0);
        run_div(16'd81, 16'd9, "after_rst", 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            ra  = 16'($urandom);
            if (sel == 0)     rb = 16'd0;
            else if (sel < 5) rb = 16'($urandom_range(1, 255));
            else              rb = 16'($urandom);
            run_div(ra, rb, $sformatf("rnd%0d", i), ($urandom_range(0, 1) == 1), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
